// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, types and credit helper for the async FIFO read side
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH     = 4;
  localparam int FIFO_DEPTH     = 1 << ADDR_WIDTH;
  localparam int OBUF_DEPTH     = 2;
  localparam int LEVEL_W        = 2;

  typedef logic [LEVEL_W-1:0] level_t;

  // Words held plus words in flight, minus the one leaving, must leave room for one more.
  function automatic logic credit_ok(input level_t level, input logic pending, input logic pop);
    logic [2:0] sum;
    sum = {1'b0, level} + {2'b00, pending} - {2'b00, pop};
    return sum < 3'(OBUF_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_rd_fwft_if.sv
// rtl/fifo_rd_fwft_if.sv - FIFO read port and FWFT output stream bundle
interface fifo_rd_fwft_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH_DEF
);

  logic                  empty;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] rdata_mem;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  level_t                buf_level;

  modport master (
    input  empty, rdata_mem, out_ready,
    output r_en, out_data, out_valid, buf_level
  );

  modport slave (
    output empty, rdata_mem, out_ready,
    input  r_en, out_data, out_valid, buf_level
  );

endinterface

// File: rtl/fifo_skid2.sv
// rtl/fifo_skid2.sv - two-entry arrival-ordered output buffer with push/pop/level
module fifo_skid2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] head_data,
  output level_t                level,
  output logic                  valid
);

  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
  level_t                level_q, level_d;
  logic                  valid_q, valid_d;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    level_d = level_q;
    unique case ({push, pop})
      2'b10: begin
        level_d = level_q + 2'd1;
        if (level_q == 2'd0) slot0_d = push_data;
        else                 slot1_d = push_data;
      end
      2'b01: begin
        level_d = level_q - 2'd1;
        slot0_d = slot1_q;
      end
      2'b11: begin
        // Level is unchanged; the new word lands behind whatever remains.
        if (level_q == 2'd1) begin
          slot0_d = push_data;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_data;
        end
      end
      default: ;
    endcase
    valid_d = (level_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      level_q <= level_d;
      valid_q <= valid_d;
    end
  end

  assign head_data = slot0_q;
  assign level     = level_q;
  assign valid     = valid_q;

endmodule

// File: rtl/fifo_rd_fwft.sv
// rtl/fifo_rd_fwft.sv - FWFT read stage: credit-based read issue into a 2-entry output buffer
module fifo_rd_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic           rclk,
  input  logic           rrst_n,
  fifo_rd_fwft_if.master bus
);

  logic   rd_pending_q, rd_pending_d;
  logic   r_en;
  logic   pop;
  logic   valid;
  level_t level;

  assign pop = valid & bus.out_ready;

  // out_ready reaches r_en combinationally so a pop frees its slot in the same cycle.
  always_comb begin
    r_en         = rrst_n & ~bus.empty & credit_ok(level, rd_pending_q, pop);
    rd_pending_d = r_en;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) rd_pending_q <= 1'b0;
    else         rd_pending_q <= rd_pending_d;
  end

  fifo_skid2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (rclk),
    .rst_n    (rrst_n),
    .push     (rd_pending_q),
    .pop      (pop),
    .push_data(bus.rdata_mem),
    .head_data(bus.out_data),
    .level    (level),
    .valid    (valid)
  );

  assign bus.r_en      = r_en;
  assign bus.out_valid = valid;
  assign bus.buf_level = level;

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// tb/tb_fifo_rd_fwft.sv - self-checking bench for fifo_rd_fwft
module tb_fifo_rd_fwft;

  logic rclk;
  logic rrst_n;

  fifo_rd_fwft_if #(.DATA_WIDTH(8)) bus();

  fifo_rd_fwft #(.DATA_WIDTH(8)) dut (
    .rclk  (rclk),
    .rrst_n(rrst_n),
    .bus   (bus.master)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    logic       empty;
    logic       rdy;
    logic       exp_ren;
    logic       exp_valid;
    logic [1:0] exp_level;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       tbl [16];
  int         n_vec;
  int         n_fail;
  logic [7:0] src [$];
  logic [7:0] sb  [$];
  logic       s_ren, s_valid, s_pop, pend_m;
  logic [7:0] s_data;
  logic [1:0] s_level;
  int         ren_cnt, pop_cnt, max_level, cyc, first_pop, last_pop, guard;
  logic [7:0] held, first_word;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle(input logic e, input logic rdy);
    logic [7:0] exp_w;
    bus.empty     = e;
    bus.out_ready = rdy;
    @(negedge rclk);
    s_ren   = bus.r_en;
    s_valid = bus.out_valid;
    s_data  = bus.out_data;
    s_level = bus.buf_level;
    s_pop   = s_valid & rdy;
    chk("ren_while_empty", int'(s_ren & e), 0);
    chk("overflow", int'(pend_m && s_level == 2'd2 && !s_pop), 0);
    if (s_pop) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        exp_w = sb.pop_front();
        chk("data_order", int'(s_data), int'(exp_w));
      end
      pop_cnt++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (s_ren) ren_cnt++;
    if (int'(s_level) > max_level) max_level = int'(s_level);
    cyc++;
    @(posedge rclk);
    #1;
    pend_m = s_ren;
    if (s_ren) begin
      if (src.size() == 0) begin
        chk("read_past_src", 1, 0);
      end else begin
        bus.rdata_mem = src.pop_front();
        sb.push_back(bus.rdata_mem);
      end
    end
  endtask

  task automatic auto_cycle(input logic rdy);
    cycle(src.size() == 0, rdy);
  endtask

  task automatic clear_stats();
    ren_cnt   = 0;
    pop_cnt   = 0;
    max_level = 0;
    first_pop = -1;
    last_pop  = -1;
  endtask

  initial begin
    n_vec = 0; n_fail = 0; cyc = 0; pend_m = 1'b0;
    clear_stats();
    rrst_n        = 1'b0;
    bus.empty     = 1'b1;
    bus.out_ready = 1'b0;
    bus.rdata_mem = 8'h00;
    repeat (2) @(posedge rclk);
    #1;

    // Reset values, with empty low to show r_en is held off by reset.
    cycle(1'b0, 1'b1);
    chk("rst_ren", int'(s_ren), 0);
    chk("rst_valid", int'(s_valid), 0);
    chk("rst_level", int'(s_level), 0);
    chk("rst_data", int'(s_data), 0);
    rrst_n = 1'b1;

    // Idle for 10 cycles, then three words with 2-cycle first-word latency.
    for (int i = 0; i < 10; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 8'hA1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 8'hA2};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 8'hA3};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00};
    src = '{8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].empty, tbl[i].rdy);
      chk($sformatf("tbl%0d_ren", i), int'(s_ren), int'(tbl[i].exp_ren));
      chk($sformatf("tbl%0d_valid", i), int'(s_valid), int'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_level", i), int'(s_level), int'(tbl[i].exp_level));
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), int'(s_data), int'(tbl[i].exp_data));
    end

    // Sustained streaming of 16 words.
    clear_stats();
    for (int k = 0; k < 16; k++) src.push_back(8'(k));
    guard = 0;
    while (pop_cnt < 16 && guard < 60) begin
      auto_cycle(1'b1);
      guard++;
    end
    repeat (2) auto_cycle(1'b1);
    chk("stream_ren_cnt", ren_cnt, 16);
    chk("stream_pop_cnt", pop_cnt, 16);
    chk("stream_back_to_back", last_pop - first_pop, 15);
    chk("stream_max_level", max_level, 1);
    chk("stream_drained_valid", int'(s_valid), 0);

    // Back-pressure: hold for 8 cycles, then release.
    for (int k = 0; k < 20; k++) src.push_back(8'(8'h40 + k));
    repeat (6) auto_cycle(1'b1);
    clear_stats();
    auto_cycle(1'b0);
    held = s_data;
    chk("bp_valid", int'(s_valid), 1);
    for (int k = 0; k < 7; k++) begin
      auto_cycle(1'b0);
      chk("bp_data_stable", int'(s_data), int'(held));
    end
    chk("bp_reads_le2", int'(ren_cnt <= 2), 1);
    chk("bp_level", int'(s_level), 2);
    auto_cycle(1'b1);
    chk("bp_first_pop", int'(s_pop), 1);
    chk("bp_ren_resume", int'(s_ren), 1);
    chk("bp_first_data", int'(s_data), int'(held));
    auto_cycle(1'b1);
    chk("bp_second_pop", int'(s_pop), 1);
    guard = 0;
    while ((src.size() != 0 || sb.size() != 0) && guard < 60) begin
      auto_cycle(1'b1);
      guard++;
    end
    chk("bp_drained", sb.size() + src.size(), 0);

    // Random consumer and source stalls over 200 words.
    clear_stats();
    for (int k = 0; k < 200; k++) src.push_back(8'(k * 7 + 3));
    guard = 0;
    while (pop_cnt < 200 && guard < 3000) begin
      cycle(src.size() == 0 || $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
      guard++;
    end
    chk("rand_pop_cnt", pop_cnt, 200);
    chk("rand_sb_empty", sb.size(), 0);
    repeat (2) auto_cycle(1'b1);

    // Reset with a full output buffer, then a fresh stream.
    for (int k = 0; k < 16; k++) src.push_back(8'(8'h80 + k));
    repeat (4) auto_cycle(1'b1);
    repeat (4) auto_cycle(1'b0);
    chk("prerst_level", int'(s_level), 2);
    rrst_n = 1'b0;
    @(negedge rclk);
    chk("midrst_valid", int'(bus.out_valid), 0);
    chk("midrst_level", int'(bus.buf_level), 0);
    chk("midrst_ren", int'(bus.r_en), 0);
    src.delete();
    sb.delete();
    pend_m = 1'b0;
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
    clear_stats();
    for (int k = 0; k < 8; k++) src.push_back(8'(8'hC0 + k));
    auto_cycle(1'b1);
    chk("postrst_ren", int'(s_ren), 1);
    first_word = 8'h00;
    guard = 0;
    while (pop_cnt < 8 && guard < 40) begin
      auto_cycle(1'b1);
      if (s_pop && pop_cnt == 1) first_word = s_data;
      guard++;
    end
    chk("postrst_first_word", int'(first_word), 8'hC0);
    chk("postrst_pop_cnt", pop_cnt, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
